fetch_controller: RTL and testbench

Sequencing FSM for the 8-bit CPU front end. It owns the program counter and drives the instruction memory read strobe and instruction-register write enable. It captures the optional operand byte of two-byte instructions and hands each decoded instruction to the execute stage through a start/done handshake. It sits between the instruction memory, the instruction register and the execute/ALU control.

---
 rtl/fetch_controller.sv | 149 ++++++++++++++
 tb/tb_fetch_controller.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_controller.sv
// Instruction fetch/sequence FSM for the 8-bit CPU front end: owns the PC, fetches opcode
// and optional operand byte, and hands off to execute. Optional watchdog: FETCH_WDT_EN.
module fetch_controller #(
   parameter logic [7:0]  RESET_PC       = 8'h00,
   parameter logic [7:0]  HALT_OP        = 8'hFF,
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [7:0] ir_in,
   input  logic [7:0] mem_data,
   input  logic       exec_done,
   input  logic       branch_taken,
   input  logic [7:0] branch_target,
   output logic [7:0] pc,
   output logic       memread,
   output logic       irwrite,
   output logic [7:0] operand,
   output logic       exec_start,
   output logic       running,
   output logic       halted,
   output logic       fault
);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_FETCH   = 3'd1;
   localparam logic [2:0] S_DECODE  = 3'd2;
   localparam logic [2:0] S_OPERAND = 3'd3;
   localparam logic [2:0] S_EXECUTE = 3'd4;
   localparam logic [2:0] S_HALT    = 3'd5;

   logic [2:0] state_q, state_d;
   logic [7:0] pc_q, pc_d;
   logic [7:0] operand_q, operand_d;
   logic       first_q, first_d;
   logic       timeout;

`ifdef FETCH_WDT_EN
   localparam int unsigned WDT_W = $clog2(TIMEOUT_CYCLES) + 1;

   logic [WDT_W-1:0] wdt_q, wdt_d;
   logic             fault_q, fault_d;

   // Counter restarts in every non-EXECUTE state, so it always counts from the first EXECUTE cycle
   always_comb begin
      wdt_d = '0;
      if (state_q == S_EXECUTE) begin
         wdt_d = wdt_q + WDT_W'(1);
      end
   end

   assign timeout = (state_q == S_EXECUTE) && !exec_done &&
                    (wdt_q == WDT_W'(TIMEOUT_CYCLES - 1));

   always_comb begin
      fault_d = fault_q;
      if (timeout) begin
         fault_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wdt_q   <= '0;
         fault_q <= 1'b0;
      end else begin
         wdt_q   <= wdt_d;
         fault_q <= fault_d;
      end
   end

   assign fault = fault_q;
`else
   assign timeout = 1'b0;
   // References TIMEOUT_CYCLES so the parameter stays live when the watchdog is absent
   assign fault   = 1'b0 & (TIMEOUT_CYCLES != 0);
`endif

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      operand_d = operand_q;
      first_d   = 1'b0;
      case (state_q)
         S_IDLE, S_HALT: begin
            if (start) begin
               state_d = S_FETCH;
            end
         end
         S_FETCH: begin
            pc_d    = pc_q + 8'd1;
            state_d = S_DECODE;
         end
         S_DECODE: begin
            if (ir_in == HALT_OP) begin
               state_d = S_HALT;
            end else if (ir_in[7:6] == 2'b11) begin
               state_d = S_OPERAND;
            end else begin
               state_d = S_EXECUTE;
               first_d = 1'b1;
            end
         end
         S_OPERAND: begin
            operand_d = mem_data;
            pc_d      = pc_q + 8'd1;
            state_d   = S_EXECUTE;
            first_d   = 1'b1;
         end
         S_EXECUTE: begin
            if (exec_done) begin
               if (branch_taken) begin
                  pc_d = branch_target;
               end
               state_d = S_FETCH;
            end else if (timeout) begin
               state_d = S_HALT;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         pc_q      <= RESET_PC;
         operand_q <= 8'h00;
         first_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         operand_q <= operand_d;
         first_q   <= first_d;
      end
   end

   assign pc         = pc_q;
   assign operand    = operand_q;
   assign memread    = (state_q == S_FETCH) || (state_q == S_OPERAND);
   assign irwrite    = (state_q == S_FETCH);
   assign exec_start = first_q;
   assign running    = (state_q != S_IDLE) && (state_q != S_HALT);
   assign halted     = (state_q == S_HALT);

endmodule

// File: tb/tb_fetch_controller.sv
// Bench for fetch_controller: an instruction-level model expands each program into the
// expected per-cycle output trace; one negedge process compares the DUT against it.
module tb_fetch_controller;

   localparam int TIMEOUT = 16;
`ifdef FETCH_WDT_EN
   localparam bit WDT = 1'b1;
`else
   localparam bit WDT = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic [7:0] ir_in, mem_data;
   logic       exec_done = 1'b0;
   logic       branch_taken = 1'b0;
   logic [7:0] branch_target = 8'h00;
   logic [7:0] pc, operand;
   logic       memread, irwrite, exec_start, running, halted, fault;

   logic       rst2 = 1'b1;
   logic       start2 = 1'b0;
   logic [7:0] ir2, mem_data2, pc2, operand2;
   logic       memread2, irwrite2, exec_start2, running2, halted2, fault2;
   logic       done2_tie = 1'b1;
   logic       bt2_tie = 1'b0;
   logic [7:0] tgt2_tie = 8'h00;

   logic [7:0] mem  [256];
   logic [7:0] mem2 [256];
   int         wait_tbl [256];
   bit         br_tbl [256];
   logic [7:0] tgt_tbl [256];
   logic [7:0] ir;

   typedef struct {
      logic [21:0] exp;
      logic        ds, dd, db;
      logic [7:0]  dt;
   } rec_t;

   rec_t       q[$];
   rec_t       cur;
   bit         active = 1'b0;
   bit         noise = 1'b0;
   logic [7:0] m_pc, m_opnd;
   bit         m_fault;
   int         checks = 0;
   int         fails = 0;

   always #5 clk = ~clk;

   assign mem_data  = mem[pc];
   assign ir_in     = ir;
   assign mem_data2 = mem2[pc2];

   always @(posedge clk) if (irwrite) ir <= mem_data;
   always @(posedge clk) if (irwrite2) ir2 <= mem_data2;

   fetch_controller #(.RESET_PC(8'h00), .HALT_OP(8'hFF), .TIMEOUT_CYCLES(TIMEOUT)) dut (
      .clk(clk), .rst(rst), .start(start), .ir_in(ir_in), .mem_data(mem_data),
      .exec_done(exec_done), .branch_taken(branch_taken), .branch_target(branch_target),
      .pc(pc), .memread(memread), .irwrite(irwrite), .operand(operand),
      .exec_start(exec_start), .running(running), .halted(halted), .fault(fault));

   fetch_controller #(.RESET_PC(8'hFF), .HALT_OP(8'hFF), .TIMEOUT_CYCLES(TIMEOUT)) dut2 (
      .clk(clk), .rst(rst2), .start(start2), .ir_in(ir2), .mem_data(mem_data2),
      .exec_done(done2_tie), .branch_taken(bt2_tie), .branch_target(tgt2_tie),
      .pc(pc2), .memread(memread2), .irwrite(irwrite2), .operand(operand2),
      .exec_start(exec_start2), .running(running2), .halted(halted2), .fault(fault2));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Packed expectation layout: {pc, memread, irwrite, exec_start, running, halted, fault, operand}
   task automatic emit(input logic [7:0] pe, input bit mr, iw, es, run, hlt,
                       input bit ds, dd, db, input logic [7:0] dt);
      rec_t r;
      r.exp = {pe, mr, iw, es, run, hlt, m_fault, m_opnd};
      r.ds = ds; r.dd = dd; r.db = db; r.dt = dt;
      q.push_back(r);
   endtask

   task automatic gen(input int restarts);
      int         rs = restarts;
      int         w;
      logic [7:0] a, op;
      bit         stop = 1'b0;
      bit         halt_now, done, to;
      emit(m_pc, 0, 0, 0, 0, 0, 1, noise, noise, 8'h5A);
      for (int n = 0; n < 64 && !stop; n++) begin
         a  = m_pc;
         op = mem[a];
         emit(m_pc, 1, 1, 0, 1, 0, noise, noise, noise, 8'h5A);
         m_pc = m_pc + 8'd1;
         emit(m_pc, 0, 0, 0, 1, 0, noise, noise, noise, 8'h5A);
         halt_now = (op == 8'hFF);
         if (!halt_now) begin
            if (op[7:6] == 2'b11) begin
               emit(m_pc, 1, 0, 0, 1, 0, noise, noise, noise, 8'h5A);
               m_opnd = mem[m_pc];
               m_pc   = m_pc + 8'd1;
            end
            w  = wait_tbl[a];
            to = 1'b0;
            for (int i = 0; i <= w; i++) begin
               done = (i == w);
               emit(m_pc, 0, 0, (i == 0), 1, 0, noise, done, done ? br_tbl[a] : noise, tgt_tbl[a]);
               if (!done && WDT && i == TIMEOUT - 1) begin
                  to = 1'b1;
                  break;
               end
            end
            if (to) begin
               m_fault  = 1'b1;
               halt_now = 1'b1;
            end else if (br_tbl[a]) begin
               m_pc = tgt_tbl[a];
            end
         end
         if (halt_now) begin
            emit(m_pc, 0, 0, 0, 0, 1, 0, noise, noise, 8'h5A);
            if (rs > 0) begin
               rs--;
               emit(m_pc, 0, 0, 0, 0, 1, 1, noise, noise, 8'h5A);
            end else begin
               emit(m_pc, 0, 0, 0, 0, 1, 0, noise, noise, 8'h5A);
               emit(m_pc, 0, 0, 0, 0, 1, 0, noise, noise, 8'h5A);
               stop = 1'b1;
            end
         end
      end
   endtask

   always @(negedge clk) begin
      if (active && q.size() > 0) begin
         cur = q.pop_front();
         chk("cycle", {10'd0, pc, memread, irwrite, exec_start, running, halted, fault, operand},
             {10'd0, cur.exp});
         start = cur.ds; exec_done = cur.dd; branch_taken = cur.db; branch_target = cur.dt;
      end else begin
         start = 1'b0; exec_done = 1'b0; branch_taken = 1'b0; branch_target = 8'h00;
      end
   end

   task automatic clear_mem();
      for (int i = 0; i < 256; i++) begin
         mem[i] = 8'hFF; wait_tbl[i] = 0; br_tbl[i] = 1'b0; tgt_tbl[i] = 8'h00;
      end
   endtask

   task automatic prep(input int restarts);
      active = 1'b0;
      rst    = 1'b1;
      m_pc = 8'h00; m_opnd = 8'h00; m_fault = 1'b0;
      q.delete();
      gen(restarts);
   endtask

   task automatic release_rst();
      @(posedge clk);
      #1;
      chk("reset_state", {10'd0, pc, memread, irwrite, exec_start, running, halted, fault, operand}, 32'd0);
      rst    = 1'b0;
      active = 1'b1;
   endtask

   task automatic go();
      release_rst();
      for (int c = 0; c < 3000 && q.size() != 0; c++) @(posedge clk);
      chk("trace_drained", q.size(), 0);
      active = 1'b0;
   endtask

   initial begin
      // Separate instance with RESET_PC=FF: two-byte opcode at FF takes its operand from 00
      for (int i = 0; i < 256; i++) mem2[i] = 8'hFF;
      mem2[8'hFF] = 8'hC7; mem2[8'h00] = 8'h5E;
      @(posedge clk); #1 rst2 = 1'b0;
      @(negedge clk); chk("w2_reset_pc", pc2, 8'hFF); start2 = 1'b1;
      @(negedge clk); start2 = 1'b0; chk("w2_fetch", {pc2, memread2, irwrite2}, {8'hFF, 2'b11});
      @(negedge clk); chk("w2_decode_pc", pc2, 8'h00);
      @(negedge clk); chk("w2_operand", {pc2, memread2, irwrite2}, {8'h00, 2'b10});
      @(negedge clk); chk("w2_execute", {pc2, exec_start2, operand2}, {8'h01, 1'b1, 8'h5E});
      repeat (3) @(negedge clk);
      chk("w2_halt", {pc2, halted2, running2}, {8'h02, 2'b10});

      // One-byte instruction, single-cycle execute
      clear_mem(); noise = 1'b0;
      mem[8'h00] = 8'h12;
      prep(0);
      chk("pin_s1_fetch", q[1].exp, {8'h00, 6'b110100, 8'h00});
      chk("pin_s1_exec", q[3].exp, {8'h01, 6'b001100, 8'h00});
      chk("pin_s1_refetch", q[4].exp, {8'h01, 6'b110100, 8'h00});
      go();

      // Two-byte instruction, operand held across a later one-byte instruction
      clear_mem(); noise = 1'b1;
      mem[8'h00] = 8'hC5; mem[8'h01] = 8'h3A; mem[8'h02] = 8'h12; wait_tbl[8'h02] = 2;
      prep(0);
      chk("pin_s2_operand", q[3].exp, {8'h01, 6'b100100, 8'h00});
      chk("pin_s2_exec", q[4].exp, {8'h02, 6'b001100, 8'h3A});
      go();
      chk("s2_end", {pc, operand, halted}, {8'h04, 8'h3A, 1'b1});

      // Branches taken/not taken, FF->00 fetch wrap, halt then restart
      clear_mem(); noise = 1'b1;
      mem[8'h00] = 8'h20; br_tbl[8'h00] = 1'b1; tgt_tbl[8'h00] = 8'h40;
      mem[8'h40] = 8'h21; wait_tbl[8'h40] = 1; tgt_tbl[8'h40] = 8'h99;
      mem[8'h41] = 8'hE3; mem[8'h42] = 8'h77; br_tbl[8'h41] = 1'b1; tgt_tbl[8'h41] = 8'hFF;
      mem[8'hFF] = 8'h07; br_tbl[8'hFF] = 1'b1; tgt_tbl[8'hFF] = 8'h10;
      mem[8'h11] = 8'h12;
      prep(1);
      chk("pin_s3_branch", q[4].exp, {8'h40, 6'b110100, 8'h00});
      go();
      chk("s3_end", {pc, operand, halted}, {8'h13, 8'h77, 1'b1});

      // Two-byte opcode at FF reached by branch: operand from 00
      clear_mem(); noise = 1'b0;
      mem[8'h00] = 8'h31; br_tbl[8'h00] = 1'b1; tgt_tbl[8'h00] = 8'hFF;
      mem[8'hFF] = 8'hC9;
      prep(0);
      chk("pin_s4_wrap_op", q[6].exp, {8'h00, 6'b100100, 8'h00});
      chk("pin_s4_exec", q[7].exp, {8'h01, 6'b001100, 8'h31});
      go();
      chk("s4_end", {pc, operand}, {8'h02, 8'h31});

      // HALT as first opcode, then restart from pc=01
      clear_mem(); noise = 1'b0;
      mem[8'h01] = 8'h12;
      prep(1);
      chk("pin_s5_halt", q[3].exp, {8'h01, 6'b000010, 8'h00});
      chk("pin_s5_restart", q[5].exp, {8'h01, 6'b110100, 8'h00});
      go();

      // Long execute: done on the 16th cycle, then 21 cycles (watchdog trips if present)
      clear_mem(); noise = 1'b1;
      mem[8'h00] = 8'h13; wait_tbl[8'h00] = TIMEOUT - 1;
      mem[8'h01] = 8'h14; wait_tbl[8'h01] = 20;
      mem[8'h02] = 8'h15;
      prep(1);
      go();
      chk("s6_end", {pc, fault}, {(WDT ? 8'h04 : 8'h05), WDT});

      // Asynchronous reset during the second OPERAND cycle
      clear_mem(); noise = 1'b0;
      mem[8'h00] = 8'hC5; mem[8'h01] = 8'h3A; mem[8'h02] = 8'hC6; mem[8'h03] = 8'h99;
      prep(0);
      release_rst();
      repeat (8) @(negedge clk);
      #2;
      chk("pre_rst_operand", {pc, memread, irwrite, operand}, {8'h03, 2'b10, 8'h3A});
      active = 1'b0;
      rst    = 1'b1;
      #1;
      chk("async_reset", {10'd0, pc, memread, irwrite, exec_start, running, halted, fault, operand}, 32'd0);
      q.delete();
      repeat (2) @(posedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
